// File: rtl/note_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : note_dispatcher_pkg
//  Purpose  : Shared slot-state encodings and note constants for the note
//             dispatcher and its pending-note queue.
//  Revision : 1.0  initial release
// ============================================================================
package note_dispatcher_pkg;

   // Slot lifecycle reported by each note-display slot
   typedef enum logic [1:0] {
      SLOT_IDLE   = 2'b00,
      SLOT_READY  = 2'b01,
      SLOT_MOVING = 2'b10,
      SLOT_HIT    = 2'b11
   } slot_state_e;

   // Note code meaning "nothing requested"
   localparam int NO_NOTE = 0;

   // Fold an index that may have run one lap past the slot count back into range
   function automatic int wrap_index(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/note_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : note_fifo
//  Purpose  : Pending-note queue. DEPTH must be a power of two (>= 2) so the
//             pointers wrap naturally. A push on a full queue is accepted
//             when a pop happens on the same edge.
//  Revision : 1.0  initial release
// ============================================================================
module note_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   // Qualify push/pop and compute next pointers and occupancy
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
      if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
   end

   // Pointer and occupancy registers; reset discards all queued entries
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while the queue is empty
   always_ff @(negedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/note_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : note_dispatcher
//  Purpose  : Routes incoming note codes to free note-display slots, queueing
//             notes when every slot is busy and dropping them when the queue
//             is also full. Slot choice is lowest-index or round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module note_dispatcher
   import note_dispatcher_pkg::*;
#(
   parameter int NUM_SLOTS  = 15,
   parameter int SEQ_W      = 3,
   parameter int STATE_W    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int RR_MODE    = 0,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [SEQ_W-1:0]             seq_in,
   input  logic [NUM_SLOTS*STATE_W-1:0] slot_state,
   output logic [NUM_SLOTS*SEQ_W-1:0]   seq_out,
   output logic [NUM_SLOTS-1:0]         start,
   output logic [CNT_W-1:0]             pending,
   output logic                         overflow,
   output logic [15:0]                  drop_count
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_SLOTS - 1);
   // Any state at or above this value has its MSB set, i.e. the slot is busy
   localparam logic [STATE_W-1:0] BUSY_MIN = {1'b1, {(STATE_W-1){1'b0}}};

   logic [NUM_SLOTS-1:0]       start_q, start_d;
   logic [NUM_SLOTS*SEQ_W-1:0] seq_out_q, seq_out_d;
   logic                       overflow_q, overflow_d;
   logic [15:0]                drop_count_q, drop_count_d;
   logic [IDX_W-1:0]           last_q, last_d;

   logic [NUM_SLOTS-1:0]       slot_free;
   logic                       sel_found;
   logic [IDX_W-1:0]           sel_idx;
   logic                       seq_nz, bypass, dispatch, drop;
   logic [SEQ_W-1:0]           disp_code;
   logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [SEQ_W-1:0]           fifo_dout;

   // A slot that pulsed start on the previous edge is held off because its
   // reported state has not caught up yet; start_q doubles as the hold-off mask.
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_free
      assign slot_free[i] = (slot_state[i*STATE_W +: STATE_W] < BUSY_MIN) & ~start_q[i];
   end

   // Pick one free slot, scanning from 0 or from just past the last dispatch
   always_comb begin
      int base;
      int pos;
      logic [IDX_W-1:0] pos_idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      pos       = 0;
      pos_idx   = '0;
      base      = (RR_MODE != 0) ? wrap_index(int'(last_q) + 1, NUM_SLOTS) : 0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         pos     = wrap_index(base + k, NUM_SLOTS);
         pos_idx = IDX_W'(pos);
         if (!sel_found && slot_free[pos_idx]) begin
            sel_found = 1'b1;
            sel_idx   = pos_idx;
         end
      end
   end

   // Decide between bypass, queue pop, push and drop; build next outputs
   always_comb begin
      seq_nz       = (seq_in != SEQ_W'(NO_NOTE));
      fifo_pop     = sel_found & ~fifo_empty;
      bypass       = sel_found & fifo_empty & seq_nz;
      fifo_push    = seq_nz & ~bypass;
      dispatch     = fifo_pop | bypass;
      disp_code    = fifo_empty ? seq_in : fifo_dout;
      drop         = fifo_push & fifo_full & ~fifo_pop;
      start_d      = '0;
      seq_out_d    = '0;
      if (dispatch) begin
         start_d[sel_idx]                         = 1'b1;
         seq_out_d[int'(sel_idx)*SEQ_W +: SEQ_W]  = disp_code;
      end
      last_d       = dispatch ? sel_idx : last_q;
      overflow_d   = drop;
      drop_count_d = (drop && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1 : drop_count_q;
   end

   // Register all outputs and the round-robin pointer on the falling edge
   always_ff @(negedge CLK) begin
      if (!RST_N) begin
         start_q      <= '0;
         seq_out_q    <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
         last_q       <= LAST_RST;
      end else begin
         start_q      <= start_d;
         seq_out_q    <= seq_out_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         last_q       <= last_d;
      end
   end

   note_fifo #(
      .WIDTH (SEQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (seq_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pending)
   );

   assign start      = start_q;
   assign seq_out    = seq_out_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_note_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_dispatcher
//  Purpose  : Scoreboard bench for note_dispatcher. dut0 runs lowest-index
//             selection, dut1 runs round-robin. Expected dispatches and drops
//             are queued by the stimulus; a monitor pops them as start /
//             overflow pulses appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_dispatcher;

   localparam int N  = 15;
   localparam int SW = 3;
   localparam int TW = 2;

   typedef struct {
      int slot;
      int code;
   } disp_t;

   logic          CLK   = 1'b0;
   logic          RST_N = 1'b0;
   logic [SW-1:0] seq0  = '0, seq1 = '0;
   logic [N*TW-1:0] st0 = '0, st1 = '0;

   logic [N*SW-1:0] seq_out0, seq_out1;
   logic [N-1:0]    start0, start1;
   logic [2:0]      pending0, pending1;
   logic            overflow0, overflow1;
   logic [15:0]     drop0, drop1;

   disp_t q0[$];
   disp_t q1[$];
   int    ovf_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   note_dispatcher #(.RR_MODE(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .seq_in(seq0), .slot_state(st0),
      .seq_out(seq_out0), .start(start0), .pending(pending0),
      .overflow(overflow0), .drop_count(drop0)
   );

   note_dispatcher #(.RR_MODE(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .seq_in(seq1), .slot_state(st1),
      .seq_out(seq_out1), .start(start1), .pending(pending1),
      .overflow(overflow1), .drop_count(drop1)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs, then let the DUT take them on the falling edge
   task automatic tick(input logic [SW-1:0] s, input logic [N*TW-1:0] st);
      seq0 = s;
      st0  = st;
      @(negedge CLK);
      #1;
   endtask

   // Monitor: compare every start / overflow pulse against the scoreboard
   initial begin
      disp_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (start0 != '0) begin
            if (q0.size() == 0) check("dut0_unexpected_start", 64'(start0), 64'd0);
            else begin
               e = q0.pop_front();
               check("dut0_start", 64'(start0), 64'd1 << e.slot);
               check("dut0_seq_out", 64'(seq_out0), 64'(e.code) << (e.slot * SW));
            end
         end
         if (start1 != '0) begin
            if (q1.size() == 0) check("dut1_unexpected_start", 64'(start1), 64'd0);
            else begin
               e = q1.pop_front();
               check("dut1_start", 64'(start1), 64'd1 << e.slot);
               check("dut1_seq_out", 64'(seq_out1), 64'(e.code) << (e.slot * SW));
            end
         end
         if (overflow0) begin
            if (ovf_q.size() == 0) check("dut0_unexpected_overflow", 64'(overflow0), 64'd0);
            else check("dut0_drop_count", 64'(drop0), 64'(ovf_q.pop_front()));
         end
         if (overflow1) check("dut1_unexpected_overflow", 64'(overflow1), 64'd0);
      end
   end

   // Stimulus
   initial begin
      logic [N*TW-1:0] hit;
      logic [N*TW-1:0] s7free;
      int guard;
      hit    = {N{2'b11}};
      s7free = hit & ~((N*TW)'(3) << 14);

      // Reset with a request present: nothing may come out
      RST_N = 1'b0;
      tick(3'd5, '0);
      tick(3'd5, '0);
      check("rst_start",    64'(start0),    64'd0);
      check("rst_seq_out",  64'(seq_out0),  64'd0);
      check("rst_pending",  64'(pending0),  64'd0);
      check("rst_overflow", 64'(overflow0), 64'd0);
      check("rst_drop",     64'(drop0),     64'd0);
      check("rst_pending1", 64'(pending1),  64'd0);

      // Bypass into slot 0
      RST_N = 1'b1;
      q0.push_back('{0, 5});
      tick(3'd5, '0);
      check("bypass_pending", 64'(pending0), 64'd0);
      tick(3'd0, '0);
      tick(3'd0, '0);

      // Slots 0-2 moving: slot 3 chosen, then hold-off pushes the next to slot 4
      q0.push_back('{3, 3});
      tick(3'd3, (N*TW)'(30'h2A));
      q0.push_back('{4, 4});
      tick(3'd4, (N*TW)'(30'h2A));
      check("holdoff_pending", 64'(pending0), 64'd0);
      tick(3'd0, '0);

      // All slots hit: fill the queue, then drop the fifth note
      for (int v = 1; v <= 4; v++) begin
         tick(SW'(v), hit);
         check("fill_pending", 64'(pending0), 64'(v));
      end
      ovf_q.push_back(1);
      tick(3'd5, hit);
      check("drop_pending",  64'(pending0),  64'd4);
      check("drop_overflow", 64'(overflow0), 64'd1);
      check("drop_count",    64'(drop0),     64'd1);

      // Slot 7 frees with the queue full: head goes out, 6 goes in
      q0.push_back('{7, 1});
      tick(3'd6, s7free);
      check("fullswap_pending",  64'(pending0),  64'd4);
      check("fullswap_overflow", 64'(overflow0), 64'd0);
      tick(3'd0, s7free);
      check("s7_holdoff_pending", 64'(pending0), 64'd4);
      q0.push_back('{7, 2});
      tick(3'd0, s7free);
      check("s7_pop_pending", 64'(pending0), 64'd3);

      // Reset mid-queue discards queued notes
      RST_N = 1'b0;
      tick(3'd0, hit);
      check("midrst_pending",  64'(pending0),  64'd0);
      check("midrst_start",    64'(start0),    64'd0);
      check("midrst_seq_out",  64'(seq_out0),  64'd0);
      check("midrst_overflow", 64'(overflow0), 64'd0);
      check("midrst_drop",     64'(drop0),     64'd0);
      RST_N = 1'b1;
      tick(3'd0, '0);
      check("postrst_pending", 64'(pending0), 64'd0);
      q0.push_back('{0, 2});
      tick(3'd2, '0);
      check("postrst_bypass_pending", 64'(pending0), 64'd0);
      tick(3'd0, '0);

      // Round-robin: 16 requests walk slots 0..14 then wrap to 0
      for (int i = 0; i < 16; i++) begin
         q1.push_back('{i % N, (i % 7) + 1});
         seq1 = SW'((i % 7) + 1);
         tick(3'd0, '0);
      end
      seq1 = '0;
      tick(3'd0, '0);
      check("rr_pending", 64'(pending1), 64'd0);

      // Bounded drain of anything still expected
      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0 || ovf_q.size() != 0) && guard < 20) begin
         tick(3'd0, '0);
         guard++;
      end
      check("q0_leftover",  64'(q0.size()),    64'd0);
      check("q1_leftover",  64'(q1.size()),    64'd0);
      check("ovf_leftover", 64'(ovf_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/note_dispatcher.md
NOTE_DISPATCHER -- requirements
Module: note_dispatcher

Interface
REQ-001 Parameter NUM_SLOTS, default 15: number of note-display slots served.
REQ-002 Parameter SEQ_W, default 3: width of a note code; code 0 means "no note".
REQ-003 Parameter STATE_W, default 2: width of each slot's state field.
REQ-004 Parameter FIFO_DEPTH, default 4: pending-note queue depth; must be a power of two and at least 2.
REQ-005 Parameter RR_MODE, default 0: 0 selects lowest-index-first slot choice; 1 selects round-robin slot choice.
REQ-006 CLK  in  1  single clock; all state updates on the falling edge.
REQ-007 RST_N  in  1  synchronous active-low reset, sampled on the CLK falling edge.
REQ-008 seq_in  in  SEQ_W  note code; every nonzero sample is one new note request.
REQ-009 slot_state  in  NUM_SLOTS*STATE_W  packed slot states; slot i occupies bits [i*STATE_W +: STATE_W].
REQ-010 seq_out  out  NUM_SLOTS*SEQ_W  packed per-slot note code, same slicing as slot_state.
REQ-011 start  out  NUM_SLOTS  one-cycle launch pulse per slot.
REQ-012 pending  out  $clog2(FIFO_DEPTH+1)  current queue occupancy.
REQ-013 overflow  out  1  one-cycle pulse when a note is dropped.
REQ-014 drop_count  out  16  saturating count of dropped notes.

Function
REQ-015 Slot i shall be free when its state MSB is 0 (states 2'b00/2'b01) and slot i is not in hold-off.
REQ-016 Hold-off: slot i shall be ineligible for selection on the edge immediately after the edge that pulsed start[i], to cover slot-state update latency.
REQ-017 At most one slot shall be dispatched per edge.
REQ-018 A dispatch shall drive start[i]=1 and seq_out slice i = dispatched code for exactly one cycle; all other start bits and seq_out slices shall be 0.
REQ-019 With no dispatch, all start bits and all seq_out slices shall be 0.
REQ-020 Bypass: with queue empty, nonzero seq_in and a free slot, seq_in shall be dispatched on the same edge (one-edge latency).
REQ-021 With queue non-empty and a free slot, the queue head shall be dispatched; a nonzero seq_in shall be pushed on the same edge, preserving arrival order.
REQ-022 With no free slot, a nonzero seq_in shall be pushed if the queue is not full.
REQ-023 With the queue full, a pop and a push on the same edge shall both succeed; occupancy is unchanged.
REQ-024 With the queue full, no dispatch and nonzero seq_in: the note shall be dropped, overflow pulsed for one cycle, and drop_count incremented, saturating at 16'hFFFF.
REQ-025 RR_MODE=0: the selected slot shall be the lowest-index free slot.
REQ-026 RR_MODE=1: the search shall start at (last dispatched index + 1) mod NUM_SLOTS and wrap; the last-dispatched index updates only on a dispatch.
REQ-027 pending shall reflect occupancy after the edge's push and pop.

Reset
REQ-028 While RST_N=0 at a falling edge: seq_out=0, start=0, overflow=0, drop_count=0, queue empty (pending=0), hold-off cleared, last-dispatched index=NUM_SLOTS-1.
REQ-029 A reset asserted mid-operation shall discard all queued notes; the first post-reset dispatch follows REQ-020.

Structure
REQ-030 The shared package shall hold the slot-state encodings (IDLE 2'b00, READY 2'b01, MOVING 2'b10, HIT 2'b11) and the NO_NOTE code constant.
REQ-031 The queue shall be a sub-module, note_fifo (parametrised width/depth, push/pop/full/empty/count, simultaneous push+pop when full).
REQ-032 Slot selection shall be combinational from registered/input state; all outputs shall be registered.

Verification
REQ-033 Reset, all slots 2'b00, seq_in=3'd5 for one cycle -> next edge: start=15'h0001, slice 0=5, pending=0.
REQ-034 Slots 0-2 at 2'b10, seq_in=3 -> start[3]=1, slice 3=3; the following edge with slot 3 still reported 2'b00 and seq_in=4 -> slot 4 is chosen (hold-off).
REQ-035 All slots 2'b11, seq_in 1,2,3,4,5 on consecutive edges -> pending reaches 4, fifth note dropped: overflow=1, drop_count=1; slot 7 then freed -> dispatches code 1 first.
REQ-036 Queue full, one slot free, seq_in=6 -> head dispatched, 6 pushed, pending stays 4, overflow=0.
REQ-037 RR_MODE=1, all slots free, 16 single-cycle requests -> slots 0..14 then 0 in order.
REQ-038 RST_N low mid-queue (pending=3) -> pending=0, outputs 0, drop_count=0 on the next edge.
